// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// data-memory wait and fixed-latency MUL/DIV, plus a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_EX,
    input  logic             MemRead_EX,
    input  logic             branch_taken_EX,
    input  logic             md_op_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready_MEM,
    output logic             PC_EN,
    output logic             IFID_EN,
    output logic             IDEX_EN,
    output logic             EXMEM_EN,
    output logic             MEMWB_EN,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             EXMEM_FLUSH,
    output logic             MEMWB_FLUSH,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, MD_WAIT} state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic       mem_stall, load_use;

    assign mem_stall = mem_req_MEM & ~mem_ready_MEM;
    assign load_use  = MemRead_EX & (rd_EX != 5'd0) &
                       ((rs1_used_ID & (rs1_ID == rd_EX)) |
                        (rs2_used_ID & (rs2_ID == rd_EX)));

    always_comb begin
        PC_EN       = 1'b1;
        IFID_EN     = 1'b1;
        IDEX_EN     = 1'b1;
        EXMEM_EN    = 1'b1;
        MEMWB_EN    = 1'b1;
        IFID_FLUSH  = 1'b0;
        IDEX_FLUSH  = 1'b0;
        EXMEM_FLUSH = 1'b0;
        MEMWB_FLUSH = 1'b0;
        md_start    = 1'b0;
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        if (!rstn) begin
            {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN} = 5'b00000;
            {IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, MEMWB_FLUSH} = 4'b1111;
            state_nxt  = RUN;
            md_cnt_nxt = 4'd0;
        end else if (mem_stall) begin
            // MUL/DIV keeps counting under a memory stall; release waits for MEM
            {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN} = 4'b0000;
            MEMWB_FLUSH = 1'b1;
            if (state == MD_WAIT && md_cnt != 4'd0)
                md_cnt_nxt = md_cnt - 4'd1;
        end else if (state == MD_WAIT) begin
            if (md_cnt != 4'd0) begin
                {PC_EN, IFID_EN, IDEX_EN} = 3'b000;
                EXMEM_FLUSH = 1'b1;
                md_cnt_nxt  = md_cnt - 4'd1;
            end else begin
                state_nxt = RUN;
            end
        end else if (md_op_EX) begin
            md_start = 1'b1;
            {PC_EN, IFID_EN, IDEX_EN} = 3'b000;
            EXMEM_FLUSH = 1'b1;
            md_cnt_nxt  = MD_LOAD;
            state_nxt   = MD_WAIT;
        end else if (branch_taken_EX) begin
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
        end else if (load_use) begin
            PC_EN      = 1'b0;
            IFID_EN    = 1'b0;
            IDEX_FLUSH = 1'b1;
        end
    end

    assign md_busy = rstn & (state == MD_WAIT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= RUN;
            md_cnt       <= 4'd0;
            stall_cycles <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (!PC_EN && stall_cycles != {CNT_W{1'b1}})
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
